cpu_eu_gen: RTL and testbench
=============================

Name: cpu_eu_gen

Overview:
Parametrised next-generation CPU execution unit. It contains a self-contained register file, ALU, program counter, instruction register and a new latched status-flag register. Relative branches are conditional on the latched flags and are evaluated inside the unit. It sits between the control-unit FSM, which drives all strobes, and the memory, which receives Address/D_out and returns D_in.

Parameters:
DW, 16, datapath / address / instruction width in bits (DW >= OFF_W + 1)
RA_W, 3, register address width; register count = 2**RA_W
OFF_W, 8, width of signed branch offset taken from IR_out[OFF_W-1:0]
PC_RST, 0, PC value after reset (DW bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
rw_en  in  1  register-file write enable
s_sel  in  1  S-operand select: 1 = D_in, 0 = reg[S_Adr]
adr_sel  in  1  Address select: 1 = reg[R_Adr], 0 = PC
ir_ld  in  1  load IR from D_in
pc_ld  in  1  PC load request
pc_inc  in  1  PC increment request
pc_sel  in  1  PC load source: 1 = ALU result (unconditional jump), 0 = PC + sext(offset) (conditional branch)
flag_ld  in  1  latch live ALU status into Flags
br_cond  in  3  branch condition code
W_Adr, R_Adr, S_Adr  in  RA_W each  write / R-read / S-read register addresses
Alu_Op  in  4  ALU operation
D_in  in  DW  memory read data
IR_out  out  DW  instruction register
ALU_Status  out  3  live {N,Z,C} of the current ALU result
Flags  out  3  latched {N,Z,C}
br_taken  out  1  branch condition true (combinational, from Flags and br_cond)
Address  out  DW  memory address
D_out  out  DW  ALU result to memory

Behaviour:
- Reset: all registers, IR_out and Flags clear to 0; PC = PC_RST. Reset overrides every other strobe in the same cycle.
- Register file:
  - Reads are combinational: R = reg[R_Adr]; S = s_sel ? D_in : reg[S_Adr].
  - Write: on a clk edge with rw_en, reg[W_Adr] <= ALU result.
  - A same-cycle read of W_Adr returns the old value; the new value is visible the next cycle.
- ALU (combinational, DW bits, results mod 2**DW):
  - 0 PASS S; 1 PASS R; 2 S+1; 3 S-1; 4 R+S; 5 R-S; 6 S>>1 logical; 7 S<<1; 8 R&S; 9 R|S; A R^S; B ~S; C 0-S; D S>>>1 arithmetic; E 0; F all-ones.
  - C flag:
    - ops 2 and 4: carry-out of the DW-bit add.
    - ops 3, 5 and C: borrow, i.e. 1 when the unsigned subtrahend > minuend.
    - ops 6 and D: S[0]. Op 7: S[DW-1].
    - all other ops: 0.
  - N = result[DW-1]; Z = (result == 0). ALU_Status = {N,Z,C}. D_out = result.
- Flags: on a clk edge with flag_ld, Flags <= ALU_Status; otherwise Flags holds.
- br_cond, evaluated on Flags (not live status): 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 !N; 7 never.
- PC update, priority order per cycle:
  1. reset -> PC = PC_RST.
  2. pc_ld & pc_sel -> PC = ALU result.
  3. pc_ld & !pc_sel & br_taken -> PC = PC + sext(IR_out[OFF_W-1:0]).
  4. pc_inc -> PC + 1. This also applies when pc_ld & !pc_sel & !br_taken, so a not-taken branch falls through to the increment.
  5. otherwise PC holds.
- PC arithmetic wraps mod 2**DW in both directions. No overflow indication.
- IR: on a clk edge with ir_ld, IR <= D_in. IR_out is the registered value; a branch in the same cycle as ir_ld uses the old IR.
- Address = adr_sel ? R : PC, combinational.
- Simultaneous events:
  - rw_en, flag_ld, ir_ld and any PC action may all assert in one cycle; each acts independently.
  - A flag_ld and a conditional branch in the same cycle: the branch uses the pre-update Flags.

Test Plan:
- Reset mid-operation: assert reset while rw_en=1 and pc_inc=1 -> all regs 0, IR_out 0, Flags 0, PC=PC_RST next cycle.
- ALU and flags at DW=16: R1=FFFF, R2=0001; Alu_Op=4 with flag_ld -> result 0000, ALU_Status {0,1,1}, Flags {0,1,1} next cycle. Alu_Op=5 (R2-R1) -> 0002, C=1.
- Conditional branch taken: Flags Z=1, IR=00FC, PC=0010, pc_ld=1, pc_sel=0, br_cond=1 -> br_taken=1, PC=000C.
- Conditional branch not taken: same setup with br_cond=2 and pc_inc=1 -> PC=0011. With pc_inc=0 -> PC holds 0010.
- Jump and wrap:
  - pc_ld=1, pc_sel=1 with ALU result 1234 -> PC=1234.
  - PC=FFFF, pc_inc -> PC=0000.
  - PC=0000 with offset FF taken -> PC=FFFF.
- Read-during-write and parameterisation: write R3 with rw_en while R_Adr=3 -> old value that cycle, new value next. Rerun the ALU and branch scenarios at DW=32, RA_W=4, OFF_W=12.

Source files
------------

// File: rtl/cpu_eu_gen.sv
// Parametrised CPU execution unit: register file, ALU, PC, IR and latched N/Z/C flags.
// Conditional relative branches are resolved here from the latched flags.
module cpu_eu_gen #(
   parameter int              DW     = 16,
   parameter int              RA_W   = 3,
   parameter int              OFF_W  = 8,
   parameter logic [DW-1:0]   PC_RST = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rw_en,
   input  logic              s_sel,
   input  logic              adr_sel,
   input  logic              ir_ld,
   input  logic              pc_ld,
   input  logic              pc_inc,
   input  logic              pc_sel,
   input  logic              flag_ld,
   input  logic [2:0]        br_cond,
   input  logic [RA_W-1:0]   W_Adr,
   input  logic [RA_W-1:0]   R_Adr,
   input  logic [RA_W-1:0]   S_Adr,
   input  logic [3:0]        Alu_Op,
   input  logic [DW-1:0]     D_in,
   output logic [DW-1:0]     IR_out,
   output logic [2:0]        ALU_Status,
   output logic [2:0]        Flags,
   output logic              br_taken,
   output logic [DW-1:0]     Address,
   output logic [DW-1:0]     D_out
);

   localparam int NREG = 1 << RA_W;

   typedef enum logic [3:0] {
      OP_PASS_S = 4'h0, OP_PASS_R = 4'h1, OP_INC   = 4'h2, OP_DEC  = 4'h3,
      OP_ADD    = 4'h4, OP_SUB    = 4'h5, OP_SHR   = 4'h6, OP_SHL  = 4'h7,
      OP_AND    = 4'h8, OP_OR     = 4'h9, OP_XOR   = 4'hA, OP_NOT  = 4'hB,
      OP_NEG    = 4'hC, OP_ASR    = 4'hD, OP_ZERO  = 4'hE, OP_ONES = 4'hF
   } alu_op_e;

   logic [DW-1:0] r_regs [NREG];
   logic [DW-1:0] r_pc;
   logic [DW-1:0] r_ir;
   logic [2:0]    r_flags;

   logic [DW-1:0] w_r;
   logic [DW-1:0] w_s;
   logic [DW-1:0] w_alu;
   logic [DW:0]   w_ext;
   logic          w_c;
   logic          w_br;
   logic [DW-1:0] w_off;

   assign w_r = r_regs[R_Adr];
   assign w_s = s_sel ? D_in : r_regs[S_Adr];

   // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
   always_comb begin
      w_alu = '0;
      w_ext = '0;
      w_c   = 1'b0;
      case (alu_op_e'(Alu_Op))
         OP_PASS_S: w_alu = w_s;
         OP_PASS_R: w_alu = w_r;
         OP_INC: begin
            w_ext = {1'b0, w_s} + (DW+1)'(1);
            w_alu = w_ext[DW-1:0];
            w_c   = w_ext[DW];
         end
         OP_DEC: begin
            w_alu = w_s - DW'(1);
            w_c   = (w_s == '0);
         end
         OP_ADD: begin
            w_ext = {1'b0, w_r} + {1'b0, w_s};
            w_alu = w_ext[DW-1:0];
            w_c   = w_ext[DW];
         end
         OP_SUB: begin
            w_alu = w_r - w_s;
            w_c   = (w_s > w_r);
         end
         OP_SHR: begin
            w_alu = {1'b0, w_s[DW-1:1]};
            w_c   = w_s[0];
         end
         OP_SHL: begin
            w_alu = {w_s[DW-2:0], 1'b0};
            w_c   = w_s[DW-1];
         end
         OP_AND:  w_alu = w_r & w_s;
         OP_OR:   w_alu = w_r | w_s;
         OP_XOR:  w_alu = w_r ^ w_s;
         OP_NOT:  w_alu = ~w_s;
         OP_NEG: begin
            w_alu = '0 - w_s;
            w_c   = (w_s != '0);
         end
         OP_ASR: begin
            w_alu = {w_s[DW-1], w_s[DW-1:1]};
            w_c   = w_s[0];
         end
         OP_ZERO: w_alu = '0;
         OP_ONES: w_alu = '1;
      endcase
   end

   // Flags are {N,Z,C}; branches look only at the latched copy.
   always_comb begin
      w_br = 1'b0;
      case (br_cond)
         3'd0: w_br = 1'b1;
         3'd1: w_br = r_flags[1];
         3'd2: w_br = ~r_flags[1];
         3'd3: w_br = r_flags[0];
         3'd4: w_br = ~r_flags[0];
         3'd5: w_br = r_flags[2];
         3'd6: w_br = ~r_flags[2];
         3'd7: w_br = 1'b0;
      endcase
   end

   assign w_off = {{(DW-OFF_W){r_ir[OFF_W-1]}}, r_ir[OFF_W-1:0]};

   // NOTE: the register file is cleared on reset because software expects all registers to read 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (rw_en) begin
         r_regs[W_Adr] <= w_alu;
      end
   end

   // A not-taken conditional branch falls through to the increment branch below.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= PC_RST;
         r_ir    <= '0;
         r_flags <= '0;
      end else begin
         if (pc_ld && pc_sel)      r_pc <= w_alu;
         else if (pc_ld && w_br)   r_pc <= r_pc + w_off;
         else if (pc_inc)          r_pc <= r_pc + DW'(1);
         if (ir_ld)   r_ir    <= D_in;
         if (flag_ld) r_flags <= ALU_Status;
      end
   end

   assign ALU_Status = {w_alu[DW-1], (w_alu == '0), w_c};
   assign IR_out     = r_ir;
   assign Flags      = r_flags;
   assign br_taken   = w_br;
   assign Address    = adr_sel ? w_r : r_pc;
   assign D_out      = w_alu;

endmodule

// File: tb/tb_cpu_eu_gen.sv
// Scoreboard bench: drives two instances (16-bit and 32-bit) with shared stimulus.
module tb_cpu_eu_gen;

   typedef enum int {S_ADDR, S_DOUT, S_STAT, S_FLAGS, S_BR, S_IR} sig_e;

   typedef struct {
      string        name;
      sig_e         sig;
      logic [31:0]  e16;
      logic [31:0]  e32;
   } exp_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] s;
      logic [31:0] d16;
      logic [2:0]  st16;
      logic [31:0] d32;
      logic [2:0]  st32;
   } vec_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic        clk = 1'b0;
   logic        reset, rw_en, s_sel, adr_sel, ir_ld, pc_ld, pc_inc, pc_sel, flag_ld;
   logic [2:0]  br_cond;
   logic [3:0]  w_adr, r_adr, s_adr, alu_op;
   logic [31:0] d_in;

   logic [15:0] ir16, addr16, dout16;
   logic [2:0]  st16, fl16;
   logic        br16;
   logic [31:0] ir32, addr32, dout32;
   logic [2:0]  st32, fl32;
   logic        br32;

   always #5 clk = ~clk;

   cpu_eu_gen #(.DW(16), .RA_W(3), .OFF_W(8), .PC_RST(16'h0000)) u_dut16 (
      .clk(clk), .reset(reset), .rw_en(rw_en), .s_sel(s_sel), .adr_sel(adr_sel),
      .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel), .flag_ld(flag_ld),
      .br_cond(br_cond), .W_Adr(w_adr[2:0]), .R_Adr(r_adr[2:0]), .S_Adr(s_adr[2:0]),
      .Alu_Op(alu_op), .D_in(d_in[15:0]), .IR_out(ir16), .ALU_Status(st16),
      .Flags(fl16), .br_taken(br16), .Address(addr16), .D_out(dout16)
   );

   cpu_eu_gen #(.DW(32), .RA_W(4), .OFF_W(12), .PC_RST(32'h0000_0100)) u_dut32 (
      .clk(clk), .reset(reset), .rw_en(rw_en), .s_sel(s_sel), .adr_sel(adr_sel),
      .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel), .flag_ld(flag_ld),
      .br_cond(br_cond), .W_Adr(w_adr), .R_Adr(r_adr), .S_Adr(s_adr),
      .Alu_Op(alu_op), .D_in(d_in), .IR_out(ir32), .ALU_Status(st32),
      .Flags(fl32), .br_taken(br32), .Address(addr32), .D_out(dout32)
   );

   function automatic logic [31:0] actual16(input sig_e sig);
      case (sig)
         S_ADDR:  return {16'h0, addr16};
         S_DOUT:  return {16'h0, dout16};
         S_STAT:  return {29'h0, st16};
         S_FLAGS: return {29'h0, fl16};
         S_BR:    return {31'h0, br16};
         default: return {16'h0, ir16};
      endcase
   endfunction

   function automatic logic [31:0] actual32(input sig_e sig);
      case (sig)
         S_ADDR:  return addr32;
         S_DOUT:  return dout32;
         S_STAT:  return {29'h0, st32};
         S_FLAGS: return {29'h0, fl32};
         S_BR:    return {31'h0, br32};
         default: return ir32;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_v(input string name, input sig_e sig,
                           input logic [31:0] e16, input logic [31:0] e32);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.e16  = e16;
      e.e32  = e32;
      sb_q.push_back(e);
   endtask

   // Monitor: compares every queued expectation against both instances mid-cycle.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.name, "/dw16"}, actual16(e.sig), e.e16);
         check({e.name, "/dw32"}, actual32(e.sig), e.e32);
      end
   end

   task automatic idle();
      reset = 1'b0; rw_en = 1'b0; s_sel = 1'b0; adr_sel = 1'b0; ir_ld = 1'b0;
      pc_ld = 1'b0; pc_inc = 1'b0; pc_sel = 1'b0; flag_ld = 1'b0;
      br_cond = 3'd0; w_adr = '0; r_adr = '0; s_adr = '0; alu_op = '0; d_in = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [10] = '{
      '{4'hD, 32'h8000_8001, 32'h0000_C000, 3'b101, 32'hC000_4000, 3'b101},
      '{4'h7, 32'h8000_8001, 32'h0000_0002, 3'b001, 32'h0001_0002, 3'b001},
      '{4'h2, 32'hFFFF_FFFF, 32'h0000_0000, 3'b011, 32'h0000_0000, 3'b011},
      '{4'h3, 32'h0000_0000, 32'h0000_FFFF, 3'b101, 32'hFFFF_FFFF, 3'b101},
      '{4'hC, 32'h0000_0001, 32'h0000_FFFF, 3'b101, 32'hFFFF_FFFF, 3'b101},
      '{4'hA, 32'h0000_00FF, 32'h0000_00FE, 3'b000, 32'h0000_00FE, 3'b000},
      '{4'hB, 32'h0F0F_0F0F, 32'h0000_F0F0, 3'b100, 32'hF0F0_F0F0, 3'b100},
      '{4'h6, 32'h0000_0003, 32'h0000_0001, 3'b001, 32'h0000_0001, 3'b001},
      '{4'h9, 32'h8000_0000, 32'h0000_0001, 3'b000, 32'h8000_0001, 3'b100},
      '{4'h8, 32'hFFFF_0001, 32'h0000_0001, 3'b000, 32'h0000_0001, 3'b000}
   };

   initial begin
      idle(); reset = 1'b1; step();

      // Build up some state, then reset in the middle of activity.
      idle(); s_sel = 1'b1; d_in = 32'hFFFF_FFFF; rw_en = 1'b1; w_adr = 4'd1;
      ir_ld = 1'b1; flag_ld = 1'b1; pc_inc = 1'b1; step();
      idle(); reset = 1'b1; rw_en = 1'b1; pc_inc = 1'b1; ir_ld = 1'b1; flag_ld = 1'b1;
      s_sel = 1'b1; d_in = 32'h1234_5678; w_adr = 4'd1;
      expect_v("pre_reset_flags", S_FLAGS, 32'h4, 32'h4);
      expect_v("pre_reset_ir", S_IR, 32'h0000_FFFF, 32'hFFFF_FFFF);
      step();
      idle(); alu_op = 4'h1; r_adr = 4'd1;
      expect_v("reset_pc", S_ADDR, 32'h0, 32'h100);
      expect_v("reset_r1", S_DOUT, 32'h0, 32'h0);
      expect_v("reset_ir", S_IR, 32'h0, 32'h0);
      expect_v("reset_flags", S_FLAGS, 32'h0, 32'h0);
      step();

      // R1 = all ones, R2 = 1
      idle(); s_sel = 1'b1; d_in = 32'hFFFF_FFFF; rw_en = 1'b1; w_adr = 4'd1; step();
      idle(); s_sel = 1'b1; d_in = 32'h1; rw_en = 1'b1; w_adr = 4'd2; step();

      idle(); r_adr = 4'd1; s_adr = 4'd2; alu_op = 4'h4; flag_ld = 1'b1;
      expect_v("add_result", S_DOUT, 32'h0, 32'h0);
      expect_v("add_status", S_STAT, 32'h3, 32'h3);
      expect_v("add_flags_old", S_FLAGS, 32'h0, 32'h0);
      step();
      idle(); r_adr = 4'd2; s_adr = 4'd1; alu_op = 4'h5;
      expect_v("sub_result", S_DOUT, 32'h2, 32'h2);
      expect_v("sub_status", S_STAT, 32'h1, 32'h1);
      expect_v("add_flags_latched", S_FLAGS, 32'h3, 32'h3);
      step();

      for (int i = 0; i < 10; i++) begin
         idle(); s_sel = 1'b1; r_adr = 4'd2; alu_op = vecs[i].op; d_in = vecs[i].s;
         expect_v($sformatf("alu_op%h_result", vecs[i].op), S_DOUT, vecs[i].d16, vecs[i].d32);
         expect_v($sformatf("alu_op%h_status", vecs[i].op), S_STAT,
                  {29'h0, vecs[i].st16}, {29'h0, vecs[i].st32});
         step();
      end

      // Taken branch, with IR reload and flag reload in the same cycle.
      idle(); ir_ld = 1'b1; d_in = 32'h0000_0FFC; step();
      idle(); s_sel = 1'b1; d_in = 32'h10; pc_ld = 1'b1; pc_sel = 1'b1; step();
      idle(); pc_ld = 1'b1; br_cond = 3'd1; ir_ld = 1'b1; d_in = 32'h0;
      flag_ld = 1'b1; alu_op = 4'hF;
      expect_v("br_z_taken", S_BR, 32'h1, 32'h1);
      expect_v("br_pc_before", S_ADDR, 32'h10, 32'h10);
      expect_v("br_ir_old", S_IR, 32'h0FFC, 32'h0FFC);
      step();
      idle(); br_cond = 3'd5;
      expect_v("br_pc_taken", S_ADDR, 32'h0C, 32'h0C);
      expect_v("br_flags_new", S_FLAGS, 32'h4, 32'h4);
      expect_v("br_ir_new", S_IR, 32'h0, 32'h0);
      expect_v("br_n_taken", S_BR, 32'h1, 32'h1);
      step();

      // Not-taken branch: falls through to increment, or holds.
      idle(); s_sel = 1'b1; d_in = 32'h10; pc_ld = 1'b1; pc_sel = 1'b1; step();
      idle(); ir_ld = 1'b1; d_in = 32'h0000_0FFC; flag_ld = 1'b1; alu_op = 4'hE; step();
      idle(); pc_ld = 1'b1; br_cond = 3'd2; pc_inc = 1'b1;
      expect_v("br_nz_not_taken", S_BR, 32'h0, 32'h0);
      expect_v("nt_pc_before", S_ADDR, 32'h10, 32'h10);
      expect_v("nt_flags", S_FLAGS, 32'h2, 32'h2);
      step();
      idle(); pc_ld = 1'b1; br_cond = 3'd2;
      expect_v("nt_pc_incremented", S_ADDR, 32'h11, 32'h11);
      step();
      idle(); br_cond = 3'd4;
      expect_v("nt_pc_held", S_ADDR, 32'h11, 32'h11);
      expect_v("br_nc_taken", S_BR, 32'h1, 32'h1);
      step();

      // Jump, then wrap on increment and on a backward branch.
      idle(); s_sel = 1'b1; d_in = 32'h1234; pc_ld = 1'b1; pc_sel = 1'b1;
      expect_v("jump_alu", S_DOUT, 32'h1234, 32'h1234);
      step();
      idle(); s_sel = 1'b1; d_in = 32'hFFFF_FFFF; pc_ld = 1'b1; pc_sel = 1'b1;
      expect_v("jump_pc", S_ADDR, 32'h1234, 32'h1234);
      step();
      idle(); pc_inc = 1'b1;
      expect_v("pc_max", S_ADDR, 32'h0000_FFFF, 32'hFFFF_FFFF);
      step();
      idle(); ir_ld = 1'b1; d_in = 32'h0000_0FFF; flag_ld = 1'b1; alu_op = 4'hE;
      expect_v("pc_inc_wrap", S_ADDR, 32'h0, 32'h0);
      step();
      idle(); pc_ld = 1'b1; br_cond = 3'd1;
      expect_v("wrap_br_taken", S_BR, 32'h1, 32'h1);
      step();
      idle();
      expect_v("pc_branch_wrap", S_ADDR, 32'h0000_FFFF, 32'hFFFF_FFFF);
      step();

      // Read-during-write on R3.
      idle(); rw_en = 1'b1; w_adr = 4'd3; s_sel = 1'b1; d_in = 32'h5A5A_ABCD;
      adr_sel = 1'b1; r_adr = 4'd3;
      expect_v("rdw_old", S_ADDR, 32'h0, 32'h0);
      step();
      idle(); adr_sel = 1'b1; r_adr = 4'd3;
      expect_v("rdw_new", S_ADDR, 32'h0000_ABCD, 32'h5A5A_ABCD);
      step();

      idle();
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
